// File: rtl/ps2_key_gen_if.sv
// PS/2 key generator bundle: raw keyboard lines in, decoded event word and status pulses out.
// Latency: wiring only; the generator registers every output it drives.
// Backpressure: none; consumers detect new events by watching ps2_key[10] change.
//
// Signals:
//   ps2_clk, ps2_dat : raw PS/2 lines, asynchronous, idle high (device -> generator)
//   ps2_key[10:0]    : {toggle, pressed, extended, scan code} (generator -> consumer)
//   key_stb          : one-cycle pulse when ps2_key updates
//   frame_err        : one-cycle pulse on parity, stop-bit or timeout error
interface ps2_key_gen_if;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [10:0] ps2_key;
   logic        key_stb;
   logic        frame_err;

   // Generator side
   modport master (
      input  ps2_clk, ps2_dat,
      output ps2_key, key_stb, frame_err
   );

   // Keyboard model / consumer side
   modport slave (
      output ps2_clk, ps2_dat,
      input  ps2_key, key_stb, frame_err
   );
endinterface

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard deserialiser: strips E0/F0/E1 prefixes and publishes toggle-flagged key events.
// Latency: raw clock fall -> internal fall in 2+FILT cycles; outputs registered one cycle after stop-bit fall.
// Backpressure: none; events are fire-and-forget, ps2_key holds its value until the next event.
//
// Ports:
//   clk_sys  : system clock, all registers on its rising edge
//   reset_n  : synchronous active-low reset
//   bus      : ps2_key_gen_if.master (ps2_clk/ps2_dat in; ps2_key/key_stb/frame_err out)
module ps2_key_gen #(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 48000
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   ps2_key_gen_if.master     bus
);

   localparam int FW = $clog2(FILT + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   // Input conditioning
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall_q, fall_d;

   // Frame FSM and decoder state
   logic [1:0]    state_q, state_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic [2:0]    skip_q, skip_d;
   logic [10:0]   key_q, key_d;
   logic          stb_q, stb_d;
   logic          ferr_q, ferr_d;

   logic          byte_ok;
   logic          err;
   logic          is_resp;

   // Stability filter: a level change on the synchronised clock is only taken once it
   // has been seen on FILT consecutive samples; any bounce back restarts the count.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fall_d = 1'b0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILT - 1)) begin
            filt_d = clk_s2_q;
            fall_d = ~clk_s2_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   assign is_resp = (shift_q == 8'hFA) || (shift_q == 8'hAA) || (shift_q == 8'hEE) ||
                    (shift_q == 8'hFE) || (shift_q == 8'hFC) || (shift_q == 8'h00) ||
                    (shift_q == 8'hFF);

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      skip_d  = skip_q;
      key_d   = key_q;
      stb_d   = 1'b0;
      ferr_d  = 1'b0;
      byte_ok = 1'b0;
      err     = 1'b0;

      // Watchdog only runs inside a frame; every edge restarts it.
      if (fall_q) begin
         wd_d = '0;
      end else if (state_q != S_IDLE) begin
         wd_d = wd_q + 1'b1;
      end else begin
         wd_d = wd_q;
      end

      case (state_q)
         S_IDLE: begin
            // A high start bit is silently ignored so stray edges cannot raise errors.
            if (fall_q && !dat_s2_q) begin
               state_d = S_DATA;
               bcnt_d  = 3'd0;
            end
         end
         S_DATA: begin
            if (fall_q) begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall_q) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         default: begin
            if (fall_q) begin
               state_d = S_IDLE;
               if (dat_s2_q && (^{shift_q, par_q})) begin
                  byte_ok = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
         end
      endcase

      // fall_q resets the watchdog, so a timeout never coincides with byte acceptance.
      if (!fall_q && (state_q != S_IDLE) && (wd_q == WW'(TIMEOUT - 1))) begin
         state_d = S_IDLE;
         err     = 1'b1;
      end

      if (err) begin
         ferr_d = 1'b1;
         ext_d  = 1'b0;
         brk_d  = 1'b0;
         skip_d = 3'd0;
      end

      if (byte_ok) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (shift_q == 8'hE1) begin
            // Pause: swallow the remaining seven bytes of the sequence.
            skip_d = 3'd7;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
         end else if (!(is_resp && !ext_q && !brk_q)) begin
            key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            stb_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         fall_q   <= 1'b0;
         state_q  <= S_IDLE;
         bcnt_q   <= 3'd0;
         shift_q  <= 8'h00;
         par_q    <= 1'b0;
         wd_q     <= '0;
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         skip_q   <= 3'd0;
         key_q    <= 11'h000;
         stb_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         clk_s1_q <= bus.ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= bus.ps2_dat;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         fall_q   <= fall_d;
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         wd_q     <= wd_d;
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         skip_q   <= skip_d;
         key_q    <= key_d;
         stb_q    <= stb_d;
         ferr_q   <= ferr_d;
      end
   end

   assign bus.ps2_key   = key_q;
   assign bus.key_stb   = stb_q;
   assign bus.frame_err = ferr_q;

endmodule
